// File: rtl/param_memory_if.sv
// Bus bundle for param_memory: write/read/clear requests in, registered read data and status out.
interface param_memory_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          clr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          perr;

  modport master (
    output clr, we, waddr, wdata, re, raddr,
    input  rdata, rvalid, busy, perr
  );

  modport slave (
    input  clr, we, waddr, wdata, re, raddr,
    output rdata, rvalid, busy, perr
  );
endinterface

// File: rtl/param_memory.sv
// 2**AW x DW memory with a DEPTH-cycle clear sweep to INIT_VAL, read-first 1-cycle reads.
// Optional even-parity storage and checking is enabled by defining PARAM_MEMORY_PARITY_EN.
module param_memory #(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   AW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic             i_clk,
  input logic             i_rst,
  param_memory_if.slave   bus
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_mem [Depth];
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  logic          w_busy;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic          w_rd_en;
  logic          w_cnt_clr;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StClear;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clr during a sweep is ignored
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.clr) w_state_next = StClear;
      StClear: if (&r_cnt)  w_state_next = StIdle;
      default: w_state_next = StClear;
    endcase
  end

  // Output/datapath control; clr wins over same-cycle we/re
  always_comb begin
    w_busy    = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = bus.waddr;
    w_wr_data = bus.wdata;
    w_rd_en   = 1'b0;
    w_cnt_clr = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_wr_en   = bus.we & ~bus.clr & ~i_rst;
        w_rd_en   = bus.re & ~bus.clr & ~i_rst;
        w_cnt_clr = bus.clr;
      end
      StClear: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = r_cnt;
        w_wr_data = INIT_VAL;
      end
      default: w_busy = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Array has no reset; the sweep is what initialises it
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Nonblocking update makes a same-address we/re return the pre-write word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_en;
      if (w_rd_en) begin
        r_rdata <= r_mem[bus.raddr];
      end
    end
  end

`ifdef PARAM_MEMORY_PARITY_EN
  logic r_par [Depth];
  logic r_perr;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_par[w_wr_addr] <= ^w_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_rd_en & (r_par[bus.raddr] ^ (^r_mem[bus.raddr]));
    end
  end

  assign bus.perr = r_perr;
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = w_busy;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: an AW=8 instance (INIT_VAL 5A) and an AW=4 instance (INIT_VAL 3C).
module tb_param_memory;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  param_memory_if #(.DW(8), .AW(8)) bus8 ();
  param_memory_if #(.DW(8), .AW(4)) bus4 ();

  param_memory #(.DW(8), .AW(8), .INIT_VAL(8'h5A)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8)
  );

  param_memory #(.DW(8), .AW(4), .INIT_VAL(8'h3C)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [7:0] a, input logic [7:0] d);
    bus8.we = 1'b1; bus8.waddr = a; bus8.wdata = d;
    step();
    bus8.we = 1'b0;
  endtask

  task automatic test_reset();
    int n4, n8, guard;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus8.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy8: got %b want 1", bus8.busy); end
    n_cmp++; if (bus4.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy4: got %b want 1", bus4.busy); end
    n_cmp++; if (bus8.rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata8: got %h want 00", bus8.rdata); end
    n_cmp++; if (bus8.rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid8: got %b want 0", bus8.rvalid); end
    n_cmp++; if (bus8.perr !== 1'b0) begin n_err++; $display("FAIL rst_perr8: got %b want 0", bus8.perr); end
    n_cmp++; if (bus4.rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata4: got %h want 00", bus4.rdata); end
    n4 = 0; n8 = 0; guard = 0;
    while ((bus4.busy || bus8.busy) && guard < 400) begin
      if (bus4.busy) n4++;
      if (bus8.busy) n8++;
      guard++;
      step();
    end
    n_cmp++; if (n4 != 16) begin n_err++; $display("FAIL sweep_len4: got %0d want 16", n4); end
    n_cmp++; if (n8 != 256) begin n_err++; $display("FAIL sweep_len8: got %0d want 256", n8); end
    n_cmp++; if (bus4.rvalid !== 1'b0) begin n_err++; $display("FAIL pre_read_rvalid4: got %b want 0", bus4.rvalid); end
    for (int i = 0; i < 16; i++) begin
      bus4.re = 1'b1; bus4.raddr = 4'(i);
      step();
      n_cmp++; if (bus4.rvalid !== 1'b1) begin n_err++; $display("FAIL init_rvalid4[%0d]: got %b want 1", i, bus4.rvalid); end
      n_cmp++; if (bus4.rdata !== 8'h3C) begin n_err++; $display("FAIL init_rdata4[%0d]: got %h want 3c", i, bus4.rdata); end
    end
    bus4.re = 1'b0;
    step();
    n_cmp++; if (bus4.rvalid !== 1'b0) begin n_err++; $display("FAIL idle_rvalid4: got %b want 0", bus4.rvalid); end
  endtask

  task automatic test_write_read();
    wr8(8'h3C, 8'hA5);
    n_cmp++; if (bus8.rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 0", bus8.rvalid); end
    bus8.re = 1'b1; bus8.raddr = 8'h3C;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rvalid !== 1'b1) begin n_err++; $display("FAIL wr_rd_rvalid: got %b want 1", bus8.rvalid); end
    n_cmp++; if (bus8.rdata !== 8'hA5) begin n_err++; $display("FAIL wr_rd_data: got %h want a5", bus8.rdata); end
    n_cmp++; if (bus8.perr !== 1'b0) begin n_err++; $display("FAIL wr_rd_perr: got %b want 0", bus8.perr); end
    bus8.re = 1'b1; bus8.raddr = 8'h3D;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'h5A) begin n_err++; $display("FAIL neighbour_init: got %h want 5a", bus8.rdata); end
  endtask

  task automatic test_read_first();
    wr8(8'h10, 8'h11);
    bus8.we = 1'b1; bus8.waddr = 8'h10; bus8.wdata = 8'h22;
    bus8.re = 1'b1; bus8.raddr = 8'h10;
    step();
    bus8.we = 1'b0; bus8.re = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'h11) begin n_err++; $display("FAIL read_first_old: got %h want 11", bus8.rdata); end
    bus8.re = 1'b1;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'h22) begin n_err++; $display("FAIL read_first_new: got %h want 22", bus8.rdata); end
    step();
    n_cmp++; if (bus8.rvalid !== 1'b0) begin n_err++; $display("FAIL hold_rvalid: got %b want 0", bus8.rvalid); end
    n_cmp++; if (bus8.rdata !== 8'h22) begin n_err++; $display("FAIL hold_rdata: got %h want 22", bus8.rdata); end
  endtask

  task automatic test_back_to_back();
    bus8.we = 1'b1; bus8.waddr = 8'h20; bus8.wdata = 8'h33;
    bus8.re = 1'b1; bus8.raddr = 8'h3C;
    step();
    bus8.we = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'hA5) begin n_err++; $display("FAIL diff_addr_rd: got %h want a5", bus8.rdata); end
    bus8.raddr = 8'h20;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid: got %b want 1", bus8.rvalid); end
    n_cmp++; if (bus8.rdata !== 8'h33) begin n_err++; $display("FAIL diff_addr_wr: got %h want 33", bus8.rdata); end
  endtask

  task automatic test_clear_traffic();
    int n, nv;
    wr8(8'h80, 8'hFF);
    bus8.re = 1'b1; bus8.raddr = 8'h80;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'hFF) begin n_err++; $display("FAIL pre_clr_data: got %h want ff", bus8.rdata); end
    bus8.clr = 1'b1;
    bus8.we = 1'b1; bus8.waddr = 8'h81; bus8.wdata = 8'h77;
    bus8.re = 1'b1; bus8.raddr = 8'h80;
    step();
    bus8.clr = 1'b0;
    n_cmp++; if (bus8.busy !== 1'b1) begin n_err++; $display("FAIL clr_busy: got %b want 1", bus8.busy); end
    n_cmp++; if (bus8.rvalid !== 1'b0) begin n_err++; $display("FAIL clr_prio_rvalid: got %b want 0", bus8.rvalid); end
    n = 0; nv = 0;
    while (bus8.busy && n < 600) begin
      if (bus8.rvalid) nv++;
      bus8.we = 1'b1; bus8.waddr = 8'h80; bus8.wdata = 8'hEE;
      bus8.re = 1'b1; bus8.raddr = 8'h80;
      bus8.clr = (n == 50);
      n++;
      step();
    end
    bus8.we = 1'b0; bus8.re = 1'b0; bus8.clr = 1'b0;
    n_cmp++; if (n != 256) begin n_err++; $display("FAIL clr_len: got %0d want 256", n); end
    n_cmp++; if (nv != 0) begin n_err++; $display("FAIL busy_rvalid_count: got %0d want 0", nv); end
    n_cmp++; if (bus8.rvalid !== 1'b0) begin n_err++; $display("FAIL busy_last_rvalid: got %b want 0", bus8.rvalid); end
    bus8.re = 1'b1; bus8.raddr = 8'h80;
    step();
    n_cmp++; if (bus8.rdata !== 8'h5A) begin n_err++; $display("FAIL clr_80: got %h want 5a", bus8.rdata); end
    bus8.raddr = 8'h81;
    step();
    n_cmp++; if (bus8.rdata !== 8'h5A) begin n_err++; $display("FAIL clr_81: got %h want 5a", bus8.rdata); end
    bus8.raddr = 8'h3C;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'h5A) begin n_err++; $display("FAIL clr_3c: got %h want 5a", bus8.rdata); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    bus8.clr = 1'b1;
    step();
    bus8.clr = 1'b0;
    repeat (100) step();
    n_cmp++; if (bus8.busy !== 1'b1) begin n_err++; $display("FAIL mid_sweep_busy: got %b want 1", bus8.busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus8.rdata !== 8'h00) begin n_err++; $display("FAIL mid_rst_rdata: got %h want 00", bus8.rdata); end
    n = 0;
    while (bus8.busy && n < 600) begin
      n++;
      step();
    end
    n_cmp++; if (n != 256) begin n_err++; $display("FAIL restart_len: got %0d want 256", n); end
  endtask

  task automatic test_parity();
    wr8(8'h05, 8'h0F);
`ifdef PARAM_MEMORY_PARITY_EN
    u_dut.r_mem[5] = 8'h0E;
    bus8.re = 1'b1; bus8.raddr = 8'h05;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rvalid !== 1'b1) begin n_err++; $display("FAIL par_rvalid: got %b want 1", bus8.rvalid); end
    n_cmp++; if (bus8.perr !== 1'b1) begin n_err++; $display("FAIL par_err: got %b want 1", bus8.perr); end
    n_cmp++; if (bus8.rdata !== 8'h0E) begin n_err++; $display("FAIL par_data: got %h want 0e", bus8.rdata); end
`else
    bus8.re = 1'b1; bus8.raddr = 8'h05;
    step();
    bus8.re = 1'b0;
    n_cmp++; if (bus8.rvalid !== 1'b1) begin n_err++; $display("FAIL par_rvalid: got %b want 1", bus8.rvalid); end
    n_cmp++; if (bus8.perr !== 1'b0) begin n_err++; $display("FAIL par_off: got %b want 0", bus8.perr); end
    n_cmp++; if (bus8.rdata !== 8'h0F) begin n_err++; $display("FAIL par_data: got %h want 0f", bus8.rdata); end
`endif
    step();
    n_cmp++; if (bus8.perr !== 1'b0) begin n_err++; $display("FAIL par_idle: got %b want 0", bus8.perr); end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus8.clr = 1'b0; bus8.we = 1'b0; bus8.re = 1'b0;
    bus8.waddr = '0; bus8.wdata = '0; bus8.raddr = '0;
    bus4.clr = 1'b0; bus4.we = 1'b0; bus4.re = 1'b0;
    bus4.waddr = '0; bus4.wdata = '0; bus4.raddr = '0;
    step();
    test_reset();
    test_write_read();
    test_read_first();
    test_back_to_back();
    test_clear_traffic();
    test_reset_mid_sweep();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL provide parameter DW, default 8: data word width in bits.
REQ-002 SHALL provide parameter AW, default 8: address width in bits; DEPTH = 2**AW words.
REQ-003 SHALL provide parameter INIT_VAL, default 0 (DW bits): value written to every word by a clear sweep.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clr  input  1  request clear sweep of whole array.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  DW  write data.
REQ-011 re  input  1  read enable.
REQ-012 raddr  input  AW  read address.
REQ-013 rdata  output  DW  registered read data.
REQ-014 rvalid  output  1  rdata valid strobe, one cycle per accepted read.
REQ-015 busy  output  1  clear sweep in progress; accesses not accepted.
REQ-016 perr  output  1  parity error on the read returned this cycle.

Function
REQ-017 SHALL implement FSM states IDLE and CLEAR; reset enters CLEAR with sweep counter 0.
REQ-018 In CLEAR, SHALL write INIT_VAL to word[counter] each cycle and increment counter; after writing word DEPTH-1, SHALL go to IDLE (sweep takes exactly DEPTH cycles).
REQ-019 busy SHALL be 1 in every CLEAR cycle and 0 in IDLE.
REQ-020 In IDLE, clr=1 SHALL enter CLEAR with counter 0 next cycle; clr has priority over we/re that cycle (both dropped).
REQ-021 clr asserted during CLEAR SHALL be ignored (no restart).
REQ-022 we/re while busy=1 SHALL be dropped: no array change, no rvalid.
REQ-023 In IDLE, we=1 SHALL write wdata to word[waddr] at the clock edge.
REQ-024 In IDLE, re=1 SHALL register word[raddr] into rdata with rvalid=1 exactly one cycle later; latency 1, one read per cycle, back-to-back allowed.
REQ-025 rdata SHALL hold its last value when rvalid=0.
REQ-026 Same-cycle we and re to the same address SHALL be read-first: rdata returns the pre-write value.
REQ-027 Same-cycle we and re to different addresses SHALL both complete.
REQ-028 Addresses SHALL use full AW bits; no out-of-range case exists.

Reset
REQ-029 On rst: rdata=0, rvalid=0, perr=0, busy=1 from the next cycle, FSM=CLEAR, counter=0.
REQ-030 rst during a sweep SHALL restart the sweep from word 0.
REQ-031 Array contents SHALL be undefined only until the sweep overwrites them; no single-cycle bulk reset of the array.

Configuration
REQ-032 Macro PARAM_MEMORY_PARITY_EN SHALL control the parity feature.
REQ-033 With it defined: each word SHALL store an extra even-parity bit computed from wdata (from INIT_VAL during clear); on read, perr SHALL be 1 alongside rvalid iff stored parity mismatches the recomputed parity of the data read.
REQ-034 Without it: no parity storage; perr SHALL be constant 0.

Verification
REQ-035 Reset, AW=4: rst for 1 cycle -> busy=1 for exactly 16 cycles, then 0; read all 16 addresses -> rdata=INIT_VAL each, rvalid one cycle after each re.
REQ-036 Write/read: we waddr=8'h3C wdata=8'hA5, next cycle re raddr=8'h3C -> rvalid=1 and rdata=8'hA5 one cycle later; perr=0.
REQ-037 Read-first: word 8'h10=8'h11; same cycle we waddr=8'h10 wdata=8'h22 and re raddr=8'h10 -> rdata=8'h11; next read -> 8'h22.
REQ-038 Clear under traffic, AW=8: write 8'hFF to 8'h80, pulse clr with we active -> busy=1 for 256 cycles, we/re in that window give no rvalid; then read 8'h80 -> INIT_VAL.
REQ-039 Reset mid-sweep: rst at cycle 100 of 256-cycle sweep -> busy stays 1 for 256 more cycles from restart.
REQ-040 With PARAM_MEMORY_PARITY_EN: force-flip one stored data bit at 8'h05 via backdoor, read 8'h05 -> rvalid=1, perr=1; without macro -> perr=0.
